// File: rtl/gbc_dma_pkg.sv
// Shared types and constants for the GBC OAM/HDMA engine.
// The byte-mover state encoding and the echo-RAM page remap live here.
package gbc_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } mover_state_t;

  localparam logic [7:0] HDMA_STATUS_IDLE = 8'hFF;
  localparam logic [7:0] ECHO_PAGE_BASE   = 8'hE0;
  localparam logic [7:0] ECHO_PAGE_OFFSET = 8'h20;
  localparam int         OAM_LEN_DEFAULT  = 160;

  // Pages $E0-$FF mirror WRAM at $C0-$DF.
  function automatic logic [7:0] remap_oam_page(input logic [7:0] page);
    return (page >= ECHO_PAGE_BASE) ? page - ECHO_PAGE_OFFSET : page;
  endfunction

endpackage

// File: rtl/gbc_dma_byte_mover.sv
// One-byte-in-flight read/write handshake engine shared by the OAM and HDMA channels.
// A request is held until its ack; the read byte is latched and replayed as write data.
module gbc_dma_byte_mover
  import gbc_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_oam,
  input  logic [13:0]       i_wr_addr,
  output logic              o_idle,
  output logic              o_done,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_wr_req,
  output logic              o_wr_oam,
  output logic [13:0]       o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ack
);

  mover_state_t      r_state;
  mover_state_t      w_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [13:0]       r_wr_addr;
  logic              r_wr_oam;
  logic [DATA_W-1:0] r_wr_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: next-state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start)  w_next = RD;
      RD:      if (i_rd_ack) w_next = WR;
      WR:      if (i_wr_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_oam  <= 1'b0;
      r_wr_data <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_rd_addr <= i_rd_addr;
        r_wr_addr <= i_wr_addr;
        r_wr_oam  <= i_wr_oam;
      end
      if (r_state == RD && i_rd_ack) r_wr_data <= i_rd_data;
    end
  end

  assign o_idle    = (r_state == IDLE);
  assign o_done    = (r_state == WR) && i_wr_ack;
  assign o_rd_req  = (r_state == RD);
  assign o_wr_req  = (r_state == WR);
  assign o_rd_addr = r_rd_addr;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_oam  = r_wr_oam;
  assign o_wr_data = r_wr_data;

endmodule

// File: rtl/gbc_dma_engine.sv
// GBC DMA engine: OAM DMA ($FF46) and CGB HDMA ($FF51-$FF55) sharing one byte mover.
// HDMA bytes win arbitration whenever the mover is idle; in-flight bytes always complete.
module gbc_dma_engine
  import gbc_dma_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int OAM_LEN    = OAM_LEN_DEFAULT,
  parameter int HDMA_BLOCK = 16,
  parameter int LEN_W      = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_oam_start,
  input  logic [7:0]        i_oam_page,
  input  logic [ADDR_W-1:0] i_hdma_src,
  input  logic [12:0]       i_hdma_dst,
  input  logic              i_hdma_ctl_wr,
  input  logic [7:0]        i_hdma_ctl_data,
  input  logic              i_vram_bank,
  input  logic              i_hblank,
  input  logic              i_lcd_on,
  output logic [7:0]        o_hdma_status,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_wr_req,
  output logic              o_wr_oam,
  output logic [13:0]       o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_oam_busy,
  output logic              o_cpu_hold
);

  localparam int BLK_W = $clog2(HDMA_BLOCK);

  // OAM channel
  logic              r_oam_busy;
  logic              r_oam_restart;
  logic [7:0]        r_oam_page;
  logic [7:0]        r_oam_idx;

  // HDMA channel
  logic              r_hdma_active;
  logic              r_hdma_hbl;
  logic              r_hdma_run;
  logic              r_hdma_term;
  logic [ADDR_W-1:0] r_hdma_src;
  logic [12:0]       r_hdma_dst;
  logic [LEN_W:0]    r_hdma_rem;
  logic [BLK_W-1:0]  r_blk_cnt;
  logic [7:0]        r_status;
  logic              r_hblank_d;
  logic              r_cur_hdma;

  logic              w_mv_idle;
  logic              w_mv_done;
  logic              w_sel_hdma;
  logic              w_start;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [13:0]       w_wr_addr;
  logic              w_oam_done;
  logic              w_oam_inflight;
  logic              w_hdma_done;
  logic              w_blk_last;
  logic              w_hbl_rise;
  logic [LEN_W:0]    w_rem_dec;
  logic [LEN_W:0]    w_rem_now;
  logic [LEN_W-1:0]  w_rem_m1;

  assign w_sel_hdma = r_hdma_run;
  assign w_start    = w_mv_idle && (r_hdma_run || r_oam_busy);
  assign w_rd_addr  = w_sel_hdma ? r_hdma_src : ADDR_W'({r_oam_page, r_oam_idx});
  assign w_wr_addr  = w_sel_hdma ? {i_vram_bank, r_hdma_dst} : {6'b0, r_oam_idx};

  gbc_dma_byte_mover #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mover (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_rd_addr (w_rd_addr),
    .i_wr_oam  (!w_sel_hdma),
    .i_wr_addr (w_wr_addr),
    .o_idle    (w_mv_idle),
    .o_done    (w_mv_done),
    .o_rd_req  (o_rd_req),
    .o_rd_addr (o_rd_addr),
    .i_rd_ack  (i_rd_ack),
    .i_rd_data (i_rd_data),
    .o_wr_req  (o_wr_req),
    .o_wr_oam  (o_wr_oam),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .i_wr_ack  (i_wr_ack)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cur_hdma <= 1'b0;
    else if (w_start) r_cur_hdma <= w_sel_hdma;
  end

  assign w_oam_done     = w_mv_done && !r_cur_hdma;
  assign w_oam_inflight = (!w_mv_idle && !r_cur_hdma) || (w_start && !w_sel_hdma);

  // A restart during an in-flight OAM byte must not let that byte bump the fresh index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oam_busy    <= 1'b0;
      r_oam_restart <= 1'b0;
      r_oam_page    <= '0;
      r_oam_idx     <= '0;
    end else if (i_oam_start) begin
      r_oam_page    <= remap_oam_page(i_oam_page);
      r_oam_idx     <= '0;
      r_oam_busy    <= 1'b1;
      r_oam_restart <= w_oam_inflight && !w_oam_done;
    end else if (w_oam_done) begin
      if (r_oam_restart) begin
        r_oam_idx     <= '0;
        r_oam_restart <= 1'b0;
      end else if (r_oam_idx == 8'(OAM_LEN - 1)) begin
        r_oam_idx  <= '0;
        r_oam_busy <= 1'b0;
      end else begin
        r_oam_idx <= r_oam_idx + 1'b1;
      end
    end
  end

  assign w_hbl_rise  = i_hblank && !r_hblank_d;
  assign w_hdma_done = w_mv_done && r_cur_hdma;
  assign w_blk_last  = w_hdma_done && (r_blk_cnt == '1);
  assign w_rem_dec   = r_hdma_rem - 1'b1;
  assign w_rem_now   = w_blk_last ? w_rem_dec : r_hdma_rem;
  assign w_rem_m1    = LEN_W'(w_rem_now - 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdma_active <= 1'b0;
      r_hdma_hbl    <= 1'b0;
      r_hdma_run    <= 1'b0;
      r_hdma_term   <= 1'b0;
      r_hdma_src    <= '0;
      r_hdma_dst    <= '0;
      r_hdma_rem    <= '0;
      r_blk_cnt     <= '0;
      r_status      <= HDMA_STATUS_IDLE;
      r_hblank_d    <= 1'b0;
    end else begin
      r_hblank_d <= i_hblank;
      if (w_hdma_done) begin
        r_hdma_src <= r_hdma_src + 1'b1;
        r_hdma_dst <= r_hdma_dst + 1'b1;
        r_blk_cnt  <= r_blk_cnt + 1'b1;
      end
      if (w_blk_last) begin
        r_hdma_rem <= w_rem_dec;
        if (w_rem_dec == '0) begin
          r_hdma_active <= 1'b0;
          r_hdma_run    <= 1'b0;
          r_hdma_term   <= 1'b0;
          r_status      <= HDMA_STATUS_IDLE;
        end else if (r_hdma_term) begin
          r_hdma_active <= 1'b0;
          r_hdma_run    <= 1'b0;
          r_hdma_term   <= 1'b0;
          r_status      <= 8'({1'b1, w_rem_m1});
        end else begin
          r_hdma_run <= !r_hdma_hbl;
          r_status   <= 8'({1'b0, w_rem_m1});
        end
      end
      if (i_hdma_ctl_wr) begin
        if (!r_hdma_active) begin
          r_hdma_active <= 1'b1;
          r_hdma_hbl    <= i_hdma_ctl_data[7];
          r_hdma_run    <= !i_hdma_ctl_data[7] || !i_lcd_on;
          r_hdma_term   <= 1'b0;
          r_hdma_src    <= i_hdma_src & ~ADDR_W'(HDMA_BLOCK - 1);
          r_hdma_dst    <= i_hdma_dst & ~13'(HDMA_BLOCK - 1);
          r_hdma_rem    <= {1'b0, i_hdma_ctl_data[LEN_W-1:0]} + 1'b1;
          r_blk_cnt     <= '0;
          r_status      <= 8'({1'b0, i_hdma_ctl_data[LEN_W-1:0]});
        end else if (r_hdma_hbl && !i_hdma_ctl_data[7]) begin
          // Stop request: defer to the block boundary if a block is still moving.
          if (r_hdma_run && !w_blk_last) begin
            r_hdma_term <= 1'b1;
          end else if (w_rem_now != '0) begin
            r_hdma_active <= 1'b0;
            r_hdma_run    <= 1'b0;
            r_status      <= 8'({1'b1, w_rem_m1});
          end
        end
      end else if (r_hdma_active && r_hdma_hbl && !r_hdma_run && !r_hdma_term && w_hbl_rise) begin
        r_hdma_run <= 1'b1;
      end
    end
  end

  assign o_hdma_status = r_status;
  assign o_oam_busy    = r_oam_busy;
  assign o_cpu_hold    = r_hdma_run;

endmodule

// File: tb/tb_gbc_dma_engine.sv
// Directed self-checking bench for gbc_dma_engine: OAM DMA, GDMA, HBlank HDMA,
// termination, arbitration against a slow write port and synchronous reset.
module tb_gbc_dma_engine;

  typedef struct packed {
    logic        oam;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_rec_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_oam_start;
  logic [7:0]  i_oam_page;
  logic [15:0] i_hdma_src;
  logic [12:0] i_hdma_dst;
  logic        i_hdma_ctl_wr;
  logic [7:0]  i_hdma_ctl_data;
  logic        i_vram_bank;
  logic        i_hblank;
  logic        i_lcd_on;
  logic [7:0]  o_hdma_status;
  logic        o_rd_req;
  logic [15:0] o_rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        o_wr_req;
  logic        o_wr_oam;
  logic [13:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        wr_ack;
  logic        o_oam_busy;
  logic        o_cpu_hold;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_delay = 0;
  int          wr_wait  = 0;
  int          busy_cnt = 0;
  logic [15:0] rd_q[$];
  wr_rec_t     wr_q[$];
  wr_rec_t     mon_rec;

  always #5 clk = ~clk;

  gbc_dma_engine dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_oam_start     (i_oam_start),
    .i_oam_page      (i_oam_page),
    .i_hdma_src      (i_hdma_src),
    .i_hdma_dst      (i_hdma_dst),
    .i_hdma_ctl_wr   (i_hdma_ctl_wr),
    .i_hdma_ctl_data (i_hdma_ctl_data),
    .i_vram_bank     (i_vram_bank),
    .i_hblank        (i_hblank),
    .i_lcd_on        (i_lcd_on),
    .o_hdma_status   (o_hdma_status),
    .o_rd_req        (o_rd_req),
    .o_rd_addr       (o_rd_addr),
    .i_rd_ack        (rd_ack),
    .i_rd_data       (rd_data),
    .o_wr_req        (o_wr_req),
    .o_wr_oam        (o_wr_oam),
    .o_wr_addr       (o_wr_addr),
    .o_wr_data       (o_wr_data),
    .i_wr_ack        (wr_ack),
    .o_oam_busy      (o_oam_busy),
    .o_cpu_hold      (o_cpu_hold)
  );

  // Memory responder: reads ack immediately with data = low address byte ^ $5A.
  assign rd_ack  = o_rd_req;
  assign rd_data = o_rd_addr[7:0] ^ 8'h5A;
  assign wr_ack  = o_wr_req && (wr_wait >= wr_delay);

  always @(posedge clk) begin
    if (o_wr_req && !wr_ack) wr_wait <= wr_wait + 1;
    else                     wr_wait <= 0;
  end

  always @(negedge clk) begin
    if (o_rd_req && rd_ack) rd_q.push_back(o_rd_addr);
    if (o_wr_req && wr_ack) begin
      mon_rec.oam  = o_wr_oam;
      mon_rec.addr = o_wr_addr;
      mon_rec.data = o_wr_data;
      wr_q.push_back(mon_rec);
    end
    if (o_oam_busy) busy_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_oam(input logic [7:0] page);
    i_oam_page  = page;
    i_oam_start = 1'b1;
    tick();
    i_oam_start = 1'b0;
  endtask

  task automatic pulse_ctl(input logic [7:0] data);
    i_hdma_ctl_data = data;
    i_hdma_ctl_wr   = 1'b1;
    tick();
    i_hdma_ctl_wr   = 1'b0;
  endtask

  task automatic wait_hold(input logic level, input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_cpu_hold === level) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_oam_idle(input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_oam_busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    int b_rd, b_wr, b_busy;
    logic seen;
    i_rst = 1'b1; i_oam_start = 1'b0; i_oam_page = '0;
    i_hdma_src = '0; i_hdma_dst = '0; i_hdma_ctl_wr = 1'b0; i_hdma_ctl_data = '0;
    i_vram_bank = 1'b0; i_hblank = 1'b0; i_lcd_on = 1'b1;

    // Reset state
    repeat (3) tick();
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_status", o_hdma_status, 8'hFF);
    check("rst_rd_req", o_rd_req, 1'b0);
    check("rst_wr_req", o_wr_req, 1'b0);
    check("rst_wr_oam", o_wr_oam, 1'b0);
    check("rst_rd_addr", o_rd_addr, 16'h0000);
    check("rst_wr_addr", o_wr_addr, 14'h0000);
    check("rst_wr_data", o_wr_data, 8'h00);
    check("rst_busy", o_oam_busy, 1'b0);
    check("rst_hold", o_cpu_hold, 1'b0);

    // OAM DMA from page $C1 with same-cycle acks
    tick();
    b_rd = rd_q.size(); b_wr = wr_q.size(); b_busy = busy_cnt;
    pulse_oam(8'hC1);
    wait_oam_idle(2000, "oam_c1_timeout");
    check("oam_c1_busy_cycles", busy_cnt - b_busy, 480);
    check("oam_c1_reads", rd_q.size() - b_rd, 160);
    check("oam_c1_writes", wr_q.size() - b_wr, 160);
    if (rd_q.size() >= b_rd + 160 && wr_q.size() >= b_wr + 160) begin
      for (int i = 0; i < 160; i++) begin
        check("oam_c1_rd_addr", rd_q[b_rd+i], 16'hC100 + 16'(i));
        check("oam_c1_wr_oam", wr_q[b_wr+i].oam, 1'b1);
        check("oam_c1_wr_addr", wr_q[b_wr+i].addr, 14'(i));
        check("oam_c1_wr_data", wr_q[b_wr+i].data, 8'(i) ^ 8'h5A);
      end
    end

    // Echo page $E3 remaps to $C3
    tick();
    b_rd = rd_q.size();
    pulse_oam(8'hE3);
    wait_oam_idle(2000, "oam_e3_timeout");
    check("oam_e3_reads", rd_q.size() - b_rd, 160);
    if (rd_q.size() >= b_rd + 160) begin
      check("oam_e3_first_rd", rd_q[b_rd], 16'hC300);
      check("oam_e3_last_rd", rd_q[b_rd+159], 16'hC39F);
    end

    // GDMA: 2 blocks, low source/dest bits ignored
    tick();
    i_hdma_src = 16'h400F; i_hdma_dst = 13'h080A; i_vram_bank = 1'b0;
    b_rd = rd_q.size(); b_wr = wr_q.size();
    pulse_ctl(8'h01);
    @(negedge clk);
    check("gdma_status_start", o_hdma_status, 8'h01);
    seen = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (o_cpu_hold !== 1'b1) seen = 1'b0;
      if (i < 95) @(negedge clk);
    end
    check("gdma_hold_throughout", seen, 1'b1);
    @(negedge clk);
    check("gdma_hold_fall", o_cpu_hold, 1'b0);
    check("gdma_status_end", o_hdma_status, 8'hFF);
    check("gdma_writes", wr_q.size() - b_wr, 32);
    if (wr_q.size() >= b_wr + 32 && rd_q.size() >= b_rd + 32) begin
      for (int i = 0; i < 32; i++) begin
        check("gdma_rd_addr", rd_q[b_rd+i], 16'h4000 + 16'(i));
        check("gdma_wr_oam", wr_q[b_wr+i].oam, 1'b0);
        check("gdma_wr_addr", wr_q[b_wr+i].addr, 14'h0800 + 14'(i));
        check("gdma_wr_data", wr_q[b_wr+i].data, 8'(i) ^ 8'h5A);
      end
    end

    // HBlank HDMA: 3 blocks, dest wraps $1FFF -> $0000, bank 1
    tick();
    i_hdma_src = 16'hD000; i_hdma_dst = 13'h1FF8; i_vram_bank = 1'b1; i_lcd_on = 1'b1;
    b_rd = rd_q.size(); b_wr = wr_q.size();
    pulse_ctl(8'h82);
    @(negedge clk);
    check("hbl_status_start", o_hdma_status, 8'h02);
    tick();
    pulse_ctl(8'h85);
    @(negedge clk);
    check("hbl_restart_ignored", o_hdma_status, 8'h02);
    repeat (10) tick();
    check("hbl_no_edge_writes", wr_q.size() - b_wr, 0);
    check("hbl_no_edge_hold", o_cpu_hold, 1'b0);
    i_hblank = 1'b1;
    wait_hold(1'b1, 10, "hbl_blk1_start");
    repeat (10) tick();
    i_hblank = 1'b0;
    tick();
    i_hblank = 1'b1;
    wait_hold(1'b0, 200, "hbl_blk1_end");
    check("hbl_blk1_status", o_hdma_status, 8'h01);
    check("hbl_blk1_writes", wr_q.size() - b_wr, 16);
    repeat (30) tick();
    check("hbl_no_queue_writes", wr_q.size() - b_wr, 16);
    i_hblank = 1'b0;
    tick();
    i_hblank = 1'b1;
    wait_hold(1'b1, 10, "hbl_blk2_start");
    wait_hold(1'b0, 200, "hbl_blk2_end");
    check("hbl_blk2_status", o_hdma_status, 8'h00);
    i_hblank = 1'b0;
    tick();
    i_hblank = 1'b1;
    wait_hold(1'b1, 10, "hbl_blk3_start");
    wait_hold(1'b0, 200, "hbl_blk3_end");
    check("hbl_done_status", o_hdma_status, 8'hFF);
    check("hbl_total_writes", wr_q.size() - b_wr, 48);
    if (wr_q.size() >= b_wr + 48 && rd_q.size() >= b_rd + 48) begin
      for (int i = 0; i < 48; i++) begin
        check("hbl_rd_addr", rd_q[b_rd+i], 16'hD000 + 16'(i));
        check("hbl_wr_addr", wr_q[b_wr+i].addr,
              (i < 16) ? 14'h3FF0 + 14'(i) : 14'h2000 + 14'(i - 16));
        check("hbl_wr_data", wr_q[b_wr+i].data, 8'(i) ^ 8'h5A);
      end
    end
    i_hblank = 1'b0;

    // HBlank HDMA terminated between blocks
    tick();
    i_hdma_src = 16'hE000; i_hdma_dst = 13'h0000; i_vram_bank = 1'b0;
    b_wr = wr_q.size();
    pulse_ctl(8'h83);
    @(negedge clk);
    check("term_status_start", o_hdma_status, 8'h03);
    tick();
    i_hblank = 1'b1;
    wait_hold(1'b1, 10, "term_blk1_start");
    wait_hold(1'b0, 200, "term_blk1_end");
    check("term_blk1_status", o_hdma_status, 8'h02);
    i_hblank = 1'b0;
    tick();
    pulse_ctl(8'h00);
    @(negedge clk);
    check("term_status", o_hdma_status, 8'h82);
    tick();
    i_hblank = 1'b1;
    repeat (20) tick();
    check("term_no_more_writes", wr_q.size() - b_wr, 16);
    check("term_no_hold", o_cpu_hold, 1'b0);
    check("term_status_kept", o_hdma_status, 8'h82);
    i_hblank = 1'b0;

    // HBlank mode with LCD off runs the first block at once
    tick();
    i_lcd_on = 1'b0;
    b_wr = wr_q.size();
    pulse_ctl(8'h80);
    @(negedge clk);
    check("lcdoff_hold", o_cpu_hold, 1'b1);
    check("lcdoff_status", o_hdma_status, 8'h00);
    wait_hold(1'b0, 200, "lcdoff_end");
    check("lcdoff_done_status", o_hdma_status, 8'hFF);
    check("lcdoff_writes", wr_q.size() - b_wr, 16);

    // HDMA preempts OAM between bytes while writes take 3 cycles
    tick();
    wr_delay = 2;
    i_hdma_src = 16'hC000; i_hdma_dst = 13'h0100;
    b_wr = wr_q.size();
    pulse_oam(8'hC0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_wr_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("mix_oam_wr_seen", seen, 1'b1);
    tick();
    pulse_ctl(8'h80);
    wait_hold(1'b0, 300, "mix_hdma_end");
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_q.size() >= b_wr + 18) begin
        seen = 1'b1;
        break;
      end
    end
    check("mix_oam_resumed", seen, 1'b1);
    if (wr_q.size() >= b_wr + 18) begin
      check("mix_first_oam", wr_q[b_wr].oam, 1'b1);
      check("mix_first_idx", wr_q[b_wr].addr, 14'h0000);
      for (int i = 1; i <= 16; i++) begin
        check("mix_hdma_oam", wr_q[b_wr+i].oam, 1'b0);
        check("mix_hdma_addr", wr_q[b_wr+i].addr, 14'h0100 + 14'(i - 1));
      end
      check("mix_resume_oam", wr_q[b_wr+17].oam, 1'b1);
      check("mix_resume_idx", wr_q[b_wr+17].addr, 14'h0001);
    end
    check("mix_oam_still_busy", o_oam_busy, 1'b1);

    // Synchronous reset in the middle of an HDMA block
    tick();
    pulse_ctl(8'h80);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_cpu_hold === 1'b1 && o_wr_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst2_mid_block", seen, 1'b1);
    tick();
    i_rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst2_status", o_hdma_status, 8'hFF);
    check("rst2_rd_req", o_rd_req, 1'b0);
    check("rst2_wr_req", o_wr_req, 1'b0);
    check("rst2_wr_oam", o_wr_oam, 1'b0);
    check("rst2_rd_addr", o_rd_addr, 16'h0000);
    check("rst2_wr_addr", o_wr_addr, 14'h0000);
    check("rst2_wr_data", o_wr_data, 8'h00);
    check("rst2_busy", o_oam_busy, 1'b0);
    check("rst2_hold", o_cpu_hold, 1'b0);
    i_rst = 1'b0;
    wr_delay = 0;
    repeat (5) tick();
    check("rst2_stays_idle", o_rd_req | o_wr_req | o_oam_busy | o_cpu_hold, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
